// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED controller: debounced active-low buttons step each channel
// through OFF/ON/BLINK/BREATHE; a shared PWM counter scales output by duty.
module led_pwm_ctrl #(
  parameter int CHANNELS      = 3,
  parameter int PWM_BITS      = 8,
  parameter int LOG2DELAY     = 21,
  parameter int STEP_LOG2     = 12,
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS-1:0]          btn_n,
  input  logic [CHANNELS*PWM_BITS-1:0] duty,
  output logic [CHANNELS-1:0]          pwm,
  output logic [2*CHANNELS-1:0]        mode_o,
  output logic [CHANNELS-1:0]          press_o,
  output logic                         blink_phase
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  localparam logic [PWM_BITS-1:0]      PWM_MAX   = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0]      PWM_ZERO  = {PWM_BITS{1'b0}};
  localparam logic [DEBOUNCE_BITS-1:0] DB_MAX    = {DEBOUNCE_BITS{1'b1}};
  localparam logic [DEBOUNCE_BITS-1:0] DB_ZERO   = {DEBOUNCE_BITS{1'b0}};
  localparam logic [LOG2DELAY-1:0]     BLINK_MAX = {LOG2DELAY{1'b1}};
  localparam logic [STEP_LOG2-1:0]     STEP_MAX  = {STEP_LOG2{1'b1}};

  logic [CHANNELS-1:0]      sync1;
  logic [CHANNELS-1:0]      sync2;
  logic [CHANNELS-1:0]      stable;
  logic [CHANNELS-1:0]      stable_d;
  logic [DEBOUNCE_BITS-1:0] db_cnt [CHANNELS];
  mode_t                    mode_q [CHANNELS];
  logic [LOG2DELAY-1:0]     blink_cnt;
  logic [STEP_LOG2-1:0]     presc;
  logic [PWM_BITS-1:0]      ramp;
  logic                     ramp_down;
  logic [PWM_BITS-1:0]      pcnt;
  logic [PWM_BITS-1:0]      level      [CHANNELS];
  logic [PWM_BITS-1:0]      level_next [CHANNELS];

  function automatic mode_t next_mode(input mode_t m);
    return mode_t'(m + 2'd1);
  endfunction

  // Product kept at double width so the top half is the exact scaled level.
  function automatic logic [PWM_BITS-1:0] breathe_level(input logic [PWM_BITS-1:0] d,
                                                        input logic [PWM_BITS-1:0] r);
    logic [2*PWM_BITS-1:0] prod;
    prod = {PWM_ZERO, d} * {PWM_ZERO, r};
    return prod[2*PWM_BITS-1:PWM_BITS];
  endfunction

  // Two-flop synchroniser; idle level is released (1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= {CHANNELS{1'b1}};
      sync2 <= {CHANNELS{1'b1}};
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // Debounce, press detection on the stable falling edge, and mode stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable   <= {CHANNELS{1'b1}};
      stable_d <= {CHANNELS{1'b1}};
      press_o  <= {CHANNELS{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
        db_cnt[i] <= DB_ZERO;
        mode_q[i] <= MODE_OFF;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= DB_ZERO;
        end else if (db_cnt[i] == DB_MAX) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= DB_ZERO;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
        stable_d[i] <= stable[i];
        press_o[i]  <= stable_d[i] & ~stable[i];
        if (stable_d[i] & ~stable[i]) begin
          mode_q[i] <= next_mode(mode_q[i]);
        end else begin
          mode_q[i] <= mode_q[i];
        end
      end
    end
  end

  // Blink timebase and triangular breathe ramp that turns around at its ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= {LOG2DELAY{1'b0}};
      blink_phase <= 1'b0;
      presc       <= {STEP_LOG2{1'b0}};
      ramp        <= PWM_ZERO;
      ramp_down   <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
      if (blink_cnt == BLINK_MAX) begin
        blink_phase <= ~blink_phase;
      end else begin
        blink_phase <= blink_phase;
      end
      presc <= presc + 1'b1;
      if (presc == STEP_MAX) begin
        if (!ramp_down && ramp == PWM_MAX) begin
          ramp_down <= 1'b1;
          ramp      <= ramp - 1'b1;
        end else if (ramp_down && ramp == PWM_ZERO) begin
          ramp_down <= 1'b0;
          ramp      <= ramp + 1'b1;
        end else if (ramp_down) begin
          ramp <= ramp - 1'b1;
        end else begin
          ramp <= ramp + 1'b1;
        end
      end
    end
  end

  // Target brightness per channel from its mode.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      level_next[i] = PWM_ZERO;
      case (mode_q[i])
        MODE_OFF:     level_next[i] = PWM_ZERO;
        MODE_ON:      level_next[i] = duty[i*PWM_BITS +: PWM_BITS];
        MODE_BLINK: begin
          if (blink_phase) begin
            level_next[i] = duty[i*PWM_BITS +: PWM_BITS];
          end else begin
            level_next[i] = PWM_ZERO;
          end
        end
        MODE_BREATHE: level_next[i] = breathe_level(duty[i*PWM_BITS +: PWM_BITS], ramp);
        default:      level_next[i] = PWM_ZERO;
      endcase
    end
  end

  // PWM counter; levels reload only at the period boundary to avoid glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= PWM_ZERO;
      pwm  <= {CHANNELS{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
        level[i] <= PWM_ZERO;
      end
    end else begin
      pcnt <= pcnt + 1'b1;
      for (int i = 0; i < CHANNELS; i++) begin
        pwm[i] <= (pcnt < level[i]);
        if (pcnt == PWM_MAX) begin
          level[i] <= level_next[i];
        end else begin
          level[i] <= level[i];
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_mode
    assign mode_o[2*g +: 2] = mode_q[g];
  end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Scoreboard bench for led_pwm_ctrl: expected press events and per-PWM-period
// high counts are queued by the stimulus and checked by an independent monitor.
module tb_led_pwm_ctrl;
  localparam int CH = 3;
  localparam int PB = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CH-1:0]    btn_n;
  logic [CH*PB-1:0] duty;
  logic [CH-1:0]    pwm;
  logic [2*CH-1:0]  mode_o;
  logic [CH-1:0]    press_o;
  logic             blink_phase;

  led_pwm_ctrl #(
    .CHANNELS(CH), .PWM_BITS(PB), .LOG2DELAY(4), .STEP_LOG2(1), .DEBOUNCE_BITS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .duty(duty),
    .pwm(pwm), .mode_o(mode_o), .press_o(press_o), .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  typedef struct { int win; int h0; int h1; int h2; logic bp; } win_exp_t;
  typedef struct { logic [2:0] mask; logic [5:0] mode; int edge_n; } press_exp_t;

  win_exp_t   wq[$];
  press_exp_t pq[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         hi[CH];
  logic [5:0] model_mode;

  // Rising edges since the last reset release.
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Monitor: press events and 16-cycle PWM windows against the queues.
  initial begin
    win_exp_t   we;
    press_exp_t pe;
    int         m;
    for (int c = 0; c < CH; c++) hi[c] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int c = 0; c < CH; c++) hi[c] = 0;
      end else begin
        for (int c = 0; c < CH; c++) hi[c] += int'(pwm[c]);
        if (press_o != 3'b000) begin
          checks++;
          if (pq.size() == 0) begin
            errors++;
            $display("FAIL press_unexpected: press_o=%b mode_o=%b at edge %0d, required none",
                     press_o, mode_o, cyc);
          end else begin
            pe = pq.pop_front();
            if (press_o !== pe.mask || mode_o !== pe.mode || cyc != pe.edge_n) begin
              errors++;
              $display("FAIL press: got press_o=%b mode_o=%b edge %0d, required %b %b edge %0d",
                       press_o, mode_o, cyc, pe.mask, pe.mode, pe.edge_n);
            end
          end
        end
        if (cyc > 0 && cyc % 16 == 0) begin
          m = cyc / 16 - 1;
          while (wq.size() > 0 && wq[0].win < m) begin
            checks++;
            errors++;
            $display("FAIL window_missed: window %0d not observed, now at %0d", wq[0].win, m);
            void'(wq.pop_front());
          end
          if (wq.size() > 0 && wq[0].win == m) begin
            we = wq.pop_front();
            checks++;
            if (hi[0] != we.h0 || hi[1] != we.h1 || hi[2] != we.h2 || blink_phase !== we.bp) begin
              errors++;
              $display("FAIL window%0d: got high=%0d/%0d/%0d phase=%b, required %0d/%0d/%0d phase=%b",
                       m, hi[0], hi[1], hi[2], blink_phase, we.h0, we.h1, we.h2, we.bp);
            end
          end
          for (int c = 0; c < CH; c++) hi[c] = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_win(input int w, input int a, input int b, input int c);
    win_exp_t e;
    e.win = w; e.h0 = a; e.h1 = b; e.h2 = c; e.bp = ((w + 1) % 2) != 0;
    wq.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Hold the buttons in mask low long enough to register, then release.
  task automatic press(input logic [2:0] mask);
    press_exp_t e;
    for (int i = 0; i < CH; i++)
      if (mask[i]) model_mode[2*i +: 2] = model_mode[2*i +: 2] + 2'd1;
    e.mask = mask; e.mode = model_mode; e.edge_n = cyc + 7;
    pq.push_back(e);
    btn_n = btn_n & ~mask;
    tick(8);
    btn_n = btn_n | mask;
    tick(8);
  endtask

  function automatic int ramp_at(input int s);
    int t;
    t = s % 30;
    return (t <= 15) ? t : 30 - t;
  endfunction

  initial begin
    btn_n = 3'b111;
    duty = 12'h000;
    model_mode = 6'b000000;
    tick(3);
    check("reset_pwm", 32'(pwm), 32'h0);
    check("reset_mode", 32'(mode_o), 32'h0);
    check("reset_press", 32'(press_o), 32'h0);
    check("reset_phase", 32'(blink_phase), 32'h0);
    rst_n = 1'b1;

    // Idle: nothing lights up, nothing is pressed.
    for (int w = 0; w <= 5; w++) push_win(w, 0, 0, 0);
    tick(100);
    check("idle_mode", 32'(mode_o), 32'h0);

    // Ch0 to ON; a 3-cycle glitch on ch1 must not count.
    press(3'b001);
    btn_n[1] = 1'b0;
    tick(3);
    btn_n[1] = 1'b1;
    tick(8);
    check("glitch_mode", 32'(mode_o), 32'h01);
    tick(1);

    // ON with duty 5, 15, 0 (changes applied just after a period boundary).
    push_win(8, 0, 0, 0);
    duty[3:0] = 4'd5;
    push_win(9, 5, 0, 0);  push_win(10, 5, 0, 0);
    tick(32);
    duty[3:0] = 4'd15;
    push_win(11, 15, 0, 0); push_win(12, 15, 0, 0);
    tick(32);
    duty[3:0] = 4'd0;
    push_win(13, 0, 0, 0); push_win(14, 0, 0, 0);
    tick(32);

    // BLINK at full duty: alternate periods lit.
    duty[3:0] = 4'd15;
    press(3'b001);
    for (int w = 15; w <= 19; w++) push_win(w, ((w - 1) % 2 != 0) ? 15 : 0, 0, 0);
    tick(80);

    // BREATHE: level follows (15*ramp)>>4 sampled at each period boundary.
    press(3'b001);
    for (int w = 21; w <= 28; w++) push_win(w, (15 * ramp_at(8 * w - 1)) >> 4, 0, 0);
    tick(128);

    // All channels pressed together, then reset mid-period.
    duty = 12'hFFF;
    press(3'b111);
    push_win(30, 0, 15, 15);
    tick(21);
    check("pre_reset_pwm", 32'(pwm), 32'h6);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_pwm", 32'(pwm), 32'h0);
    check("async_reset_mode", 32'(mode_o), 32'h0);
    check("async_reset_phase", 32'(blink_phase), 32'h0);
    model_mode = 6'b000000;
    tick(3);
    rst_n = 1'b1;
    push_win(0, 0, 0, 0); push_win(1, 0, 0, 0);
    tick(40);

    check("press_queue_drained", 32'(pq.size()), 32'h0);
    check("window_queue_drained", 32'(wq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/led_pwm_ctrl.md
Name: led_pwm_ctrl

Overview:
Parametrised multi-channel LED controller that feeds the RGBA driver PWM inputs.
- Each channel has a raw active-low button with a synchroniser and debouncer.
- Each button press advances that channel through four modes: OFF, ON, BLINK, BREATHE.
- A shared PWM counter scales each channel's output by a per-channel duty input.
- Replaces hardwired button/counter wiring to the LED driver with a reusable block.

Parameters:
CHANNELS, 3, number of LED channels (>=1)
PWM_BITS, 8, PWM counter, duty and ramp width (>=2)
LOG2DELAY, 21, blink half-period is 2**LOG2DELAY cycles
STEP_LOG2, 12, breathe ramp advances one step every 2**STEP_LOG2 cycles
DEBOUNCE_BITS, 16, input must differ from stable level for 2**DEBOUNCE_BITS consecutive cycles

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
btn_n  input  CHANNELS  raw buttons, active-low, asynchronous to clk
duty  input  CHANNELS*PWM_BITS  per-channel brightness; channel i at [i*PWM_BITS +: PWM_BITS]
pwm  output  CHANNELS  PWM drive to LED driver, active-high
mode_o  output  2*CHANNELS  per-channel mode at [2i+:2]; 0 OFF, 1 ON, 2 BLINK, 3 BREATHE
press_o  output  CHANNELS  one-cycle pulse per debounced press
blink_phase  output  1  current blink phase

Behaviour:
- Reset (async assert, sync release): pwm=0, mode_o=0 (OFF), press_o=0, blink_phase=0. Synchroniser flops and stable levels = 1 (released). All counters = 0. Ramp = 0, ramp direction = up.
- Synchroniser: two flops per bit on btn_n. No other logic samples the raw btn_n.
- Debounce, per channel:
  - If synced level equals stable level, clear the counter.
  - Otherwise increment the counter; when it holds 2**DEBOUNCE_BITS-1 and the level still differs, stable takes the synced level on that edge and the counter clears.
  - A single-cycle glitch never changes stable.
- Press: press_o[i]=1 for exactly one cycle, on the edge after stable[i] goes 1->0. Release (0->1) produces no pulse.
- Mode: on the same edge press_o[i] rises, mode[i] advances OFF->ON->BLINK->BREATHE->OFF (2-bit wrap). Channels are independent; simultaneous presses on several channels each advance.
- Blink: LOG2DELAY-bit free-running counter; blink_phase toggles on each wrap to 0.
- Breathe ramp (shared):
  - STEP_LOG2-bit prescaler; on each prescaler wrap, ramp steps ±1.
  - At ramp = 2**PWM_BITS-1 while going up: direction flips, ramp steps down. At 0 while going down: direction flips, ramp steps up.
  - Ramp never wraps.
- PWM:
  - Shared PWM_BITS free-running counter pcnt.
  - Per-channel level register loads only on the edge where pcnt wraps to 0, so there are no mid-period glitches.
  - Level by mode: OFF 0; ON duty; BLINK duty if blink_phase else 0; BREATHE (duty*ramp)>>PWM_BITS, computed at full 2*PWM_BITS width.
  - pwm[i] registered = (pcnt < level[i]).
  - duty=0 gives constant 0. Max duty gives high for 2**PWM_BITS-1 of every 2**PWM_BITS cycles.
- Latency:
  - duty or mode change reaches pwm at the start of the next PWM period.
  - btn_n low to press_o is 2 + 2**DEBOUNCE_BITS + 1 rising edges.
- Reset mid-operation: all state returns to reset values immediately; pwm drops asynchronously.

Test Plan:
1. Params PWM_BITS=4, DEBOUNCE_BITS=2, LOG2DELAY=4, STEP_LOG2=1. Release reset, btn_n all 1 -> pwm=0, mode_o=0, press_o=0 for 100 cycles.
2. Hold btn_n[0]=0 -> press_o[0] is high on exactly the 7th edge only, mode_o[1:0]=1 on that same edge. Pulse btn_n[1]=0 for 3 cycles -> no press_o[1], mode unchanged.
3. Ch0 ON, duty[3:0]=5 -> from the next pcnt wrap, pwm[0] is high 5 of every 16 cycles. duty=15 -> 15/16. duty=0 -> always 0.
4. Ch0 BLINK, duty=15 -> pwm[0] is PWM-active for 16 cycles, then 0 for 16 cycles, repeating; blink_phase toggles every 16 cycles.
5. Ch0 BREATHE, duty=15 -> ramp climbs 0..15 then falls to 0 (step every 2 cycles); level tracks (15*ramp)>>4 at period boundaries.
6. Press all three channels at once, then assert rst_n=0 mid-PWM-period -> all modes advance together; on reset, pwm=0 immediately and mode_o=0.
